// File: rtl/warp_issue_pkg.sv
// Shared types and default widths for the warp issue scheduler.
// issue_t takes its widths from these constants, so they must match the top-level parameters.
package warp_issue_pkg;

  localparam int WI_ARCH_LEN     = 32;
  localparam int WI_INST_BITS    = 64;
  localparam int WI_NUM_WARPS    = 8;
  localparam int WI_NUM_LANES    = 16;
  localparam int WI_OP_BITS      = 9;
  localparam int WI_REG_BITS     = 8;
  localparam int WI_WARP_ID_BITS = $clog2(WI_NUM_WARPS);

  typedef struct packed {
    logic [WI_WARP_ID_BITS-1:0] wid;
    logic [WI_ARCH_LEN-1:0]     pc;
    logic [WI_OP_BITS-1:0]      op;
    logic [WI_REG_BITS-1:0]     rd;
    logic [WI_REG_BITS-1:0]     rs1;
    logic [WI_REG_BITS-1:0]     rs2;
    logic [WI_REG_BITS-1:0]     rs3;
    logic [WI_NUM_LANES-1:0]    tmask;
    logic [WI_INST_BITS-1:0]    raw;
  } issue_t;

endpackage

// File: rtl/warp_issue_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
// The pointer register is held by the parent.
module rr_arbiter #(
  parameter int N   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant   = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDW'((int'(ptr) + i) % N);
      if (!gnt_vld && req[idx]) begin
        grant[idx] = 1'b1;
        gnt_vld    = 1'b1;
        gnt_id     = idx;
      end
    end
  end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Picks one hazard-free warp head per cycle (round-robin), pops it, and holds it in
// a registered valid/ready issue slot; writebacks clear the per-warp register scoreboard.
module warp_issue_scheduler
  import warp_issue_pkg::*;
#(
  parameter int ARCH_LEN     = WI_ARCH_LEN,
  parameter int INST_BITS    = WI_INST_BITS,
  parameter int NUM_WARPS    = WI_NUM_WARPS,
  parameter int NUM_LANES    = WI_NUM_LANES,
  parameter int OP_BITS      = WI_OP_BITS,
  parameter int REG_BITS     = WI_REG_BITS,
  parameter int WARP_ID_BITS = $clog2(NUM_WARPS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_WARPS-1:0]           ibuf_valid,
  output logic [NUM_WARPS-1:0]           ibuf_ready,
  input  logic [NUM_WARPS*ARCH_LEN-1:0]  ibuf_pc,
  input  logic [NUM_WARPS*OP_BITS-1:0]   ibuf_op,
  input  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rd,
  input  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rs1,
  input  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rs2,
  input  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rs3,
  input  logic [NUM_WARPS*NUM_LANES-1:0] ibuf_tmask,
  input  logic [NUM_WARPS*INST_BITS-1:0] ibuf_raw,
  input  logic                           wb_valid,
  input  logic [WARP_ID_BITS-1:0]        wb_wid,
  input  logic [REG_BITS-1:0]            wb_rd,
  output logic                           issue_valid,
  input  logic                           issue_ready,
  output logic [WARP_ID_BITS-1:0]        issue_wid,
  output logic [ARCH_LEN-1:0]            issue_pc,
  output logic [OP_BITS-1:0]             issue_op,
  output logic [REG_BITS-1:0]            issue_rd,
  output logic [REG_BITS-1:0]            issue_rs1,
  output logic [REG_BITS-1:0]            issue_rs2,
  output logic [REG_BITS-1:0]            issue_rs3,
  output logic [NUM_LANES-1:0]           issue_tmask,
  output logic [INST_BITS-1:0]           issue_raw,
  output logic                           idle
);

  localparam int NUM_REGS = 2**REG_BITS;

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy_q, busy_d, busy_eff, wb_clr, rd_set;
  logic [NUM_WARPS-1:0]               elig, req, grant;
  logic                               gnt_vld, accept;
  logic [WARP_ID_BITS-1:0]            gnt_id, rr_ptr_q, rr_ptr_d;
  logic                               issue_valid_q, issue_valid_d;
  issue_t                             issue_q, issue_d;
  logic [REG_BITS-1:0]                g_rd;

  function automatic logic reg_busy(input logic [NUM_REGS-1:0] row,
                                    input logic [REG_BITS-1:0] r);
    return (r != '0) && row[r];
  endfunction

  // A writeback this cycle is bypassed into eligibility so a dependent head can pop now.
  always_comb begin
    wb_clr = '0;
    if (wb_valid && (wb_rd != '0)) wb_clr[wb_wid][wb_rd] = 1'b1;
  end

  assign busy_eff = busy_q & ~wb_clr;

  always_comb begin
    elig = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      elig[w] = ibuf_valid[w]
        && !reg_busy(busy_eff[w], ibuf_rs1[w*REG_BITS +: REG_BITS])
        && !reg_busy(busy_eff[w], ibuf_rs2[w*REG_BITS +: REG_BITS])
        && !reg_busy(busy_eff[w], ibuf_rs3[w*REG_BITS +: REG_BITS])
        && !reg_busy(busy_eff[w], ibuf_rd[w*REG_BITS +: REG_BITS]);
    end
  end

  assign accept = !issue_valid_q || issue_ready;
  assign req    = elig & {NUM_WARPS{accept && reset}};

  rr_arbiter #(
    .N   (NUM_WARPS),
    .IDW (WARP_ID_BITS)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (rr_ptr_q),
    .grant   (grant),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign ibuf_ready = grant;

  always_comb begin
    issue_d       = issue_q;
    issue_valid_d = issue_valid_q;
    rr_ptr_d      = rr_ptr_q;
    rd_set        = '0;
    g_rd          = ibuf_rd[gnt_id*REG_BITS +: REG_BITS];
    if (gnt_vld) begin
      issue_valid_d = 1'b1;
      issue_d.wid   = gnt_id;
      issue_d.pc    = ibuf_pc[gnt_id*ARCH_LEN +: ARCH_LEN];
      issue_d.op    = ibuf_op[gnt_id*OP_BITS +: OP_BITS];
      issue_d.rd    = g_rd;
      issue_d.rs1   = ibuf_rs1[gnt_id*REG_BITS +: REG_BITS];
      issue_d.rs2   = ibuf_rs2[gnt_id*REG_BITS +: REG_BITS];
      issue_d.rs3   = ibuf_rs3[gnt_id*REG_BITS +: REG_BITS];
      issue_d.tmask = ibuf_tmask[gnt_id*NUM_LANES +: NUM_LANES];
      issue_d.raw   = ibuf_raw[gnt_id*INST_BITS +: INST_BITS];
      if (g_rd != '0) rd_set[gnt_id][g_rd] = 1'b1;
      rr_ptr_d = (int'(gnt_id) == NUM_WARPS - 1) ? '0 : gnt_id + WARP_ID_BITS'(1);
    end else if (issue_valid_q && issue_ready) begin
      issue_valid_d = 1'b0;
    end
  end

  // Set after clear, so a new destination wins over a same-cycle writeback of that register.
  assign busy_d = (busy_q & ~wb_clr) | rd_set;

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q        <= '0;
      rr_ptr_q      <= '0;
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
    end else begin
      busy_q        <= busy_d;
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_q       <= issue_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_wid   = issue_q.wid;
  assign issue_pc    = issue_q.pc;
  assign issue_op    = issue_q.op;
  assign issue_rd    = issue_q.rd;
  assign issue_rs1   = issue_q.rs1;
  assign issue_rs2   = issue_q.rs2;
  assign issue_rs3   = issue_q.rs3;
  assign issue_tmask = issue_q.tmask;
  assign issue_raw   = issue_q.raw;
  assign idle        = !issue_valid_q && (busy_q == '0);

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Bench for warp_issue_scheduler: directed scenarios plus a randomized run, all
// checked against a behavioural scoreboard/round-robin model kept here.
module tb_warp_issue_scheduler;

  localparam int NW = 8;
  localparam int AL = 32;
  localparam int IB = 64;
  localparam int NL = 16;
  localparam int OB = 9;
  localparam int RB = 8;

  typedef struct packed {
    logic [AL-1:0] pc;
    logic [OB-1:0] op;
    logic [RB-1:0] rd;
    logic [RB-1:0] rs1;
    logic [RB-1:0] rs2;
    logic [RB-1:0] rs3;
    logic [NL-1:0] tm;
    logic [IB-1:0] raw;
  } inst_t;

  logic            clock = 1'b0;
  logic            reset;
  logic [NW-1:0]   ibuf_valid, ibuf_ready;
  logic [NW*AL-1:0] ibuf_pc;
  logic [NW*OB-1:0] ibuf_op;
  logic [NW*RB-1:0] ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
  logic [NW*NL-1:0] ibuf_tmask;
  logic [NW*IB-1:0] ibuf_raw;
  logic            wb_valid;
  logic [2:0]      wb_wid;
  logic [RB-1:0]   wb_rd;
  logic            issue_valid, issue_ready, idle;
  logic [2:0]      issue_wid;
  logic [AL-1:0]   issue_pc;
  logic [OB-1:0]   issue_op;
  logic [RB-1:0]   issue_rd, issue_rs1, issue_rs2, issue_rs3;
  logic [NL-1:0]   issue_tmask;
  logic [IB-1:0]   issue_raw;

  warp_issue_scheduler dut (
    .clock(clock), .reset(reset),
    .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready),
    .ibuf_pc(ibuf_pc), .ibuf_op(ibuf_op), .ibuf_rd(ibuf_rd),
    .ibuf_rs1(ibuf_rs1), .ibuf_rs2(ibuf_rs2), .ibuf_rs3(ibuf_rs3),
    .ibuf_tmask(ibuf_tmask), .ibuf_raw(ibuf_raw),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_wid(issue_wid), .issue_pc(issue_pc), .issue_op(issue_op),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs3(issue_rs3), .issue_tmask(issue_tmask), .issue_raw(issue_raw),
    .idle(idle)
  );

  always #5 clock = ~clock;

  // Stimulus state
  bit    hv[NW];
  inst_t head[NW];
  bit    wbv;
  int    wbw, wbr;
  bit    ir;
  bit    rstn;

  // Reference model state
  bit [255:0] m_busy[NW];
  int         m_ptr;
  bit         m_ov;
  int         m_wid;
  inst_t      m_out;
  int         exp_g;
  logic [NW-1:0] exp_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic bit hazard_reg(input int w, input int r);
    return (r != 0) && m_busy[w][r] && !(wbv && wbw == w && wbr == r);
  endfunction

  function automatic bit eligible(input int w);
    return hv[w] && !(hazard_reg(w, int'(head[w].rs1)) || hazard_reg(w, int'(head[w].rs2)) ||
                      hazard_reg(w, int'(head[w].rs3)) || hazard_reg(w, int'(head[w].rd)));
  endfunction

  function automatic bit m_idle();
    for (int w = 0; w < NW; w++) if (m_busy[w] != '0) return 1'b0;
    return !m_ov;
  endfunction

  task automatic drive();
    for (int w = 0; w < NW; w++) begin
      ibuf_valid[w]           = hv[w];
      ibuf_pc[w*AL +: AL]     = head[w].pc;
      ibuf_op[w*OB +: OB]     = head[w].op;
      ibuf_rd[w*RB +: RB]     = head[w].rd;
      ibuf_rs1[w*RB +: RB]    = head[w].rs1;
      ibuf_rs2[w*RB +: RB]    = head[w].rs2;
      ibuf_rs3[w*RB +: RB]    = head[w].rs3;
      ibuf_tmask[w*NL +: NL]  = head[w].tm;
      ibuf_raw[w*IB +: IB]    = head[w].raw;
    end
    wb_valid    = wbv;
    wb_wid      = 3'(wbw);
    wb_rd       = RB'(wbr);
    issue_ready = ir;
    reset       = rstn;
  endtask

  task automatic model_eval();
    exp_g = -1;
    exp_ready = '0;
    if (rstn && (!m_ov || ir)) begin
      for (int i = 0; i < NW; i++) begin
        if (exp_g < 0 && eligible((m_ptr + i) % NW)) exp_g = (m_ptr + i) % NW;
      end
    end
    if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
  endtask

  task automatic model_commit();
    if (!rstn) begin
      for (int w = 0; w < NW; w++) m_busy[w] = '0;
      m_ptr = 0; m_ov = 1'b0; m_wid = 0; m_out = '0;
    end else begin
      if (wbv && wbr != 0) m_busy[wbw][wbr] = 1'b0;
      if (exp_g >= 0) begin
        if (head[exp_g].rd != 0) m_busy[exp_g][head[exp_g].rd] = 1'b1;
        m_out = head[exp_g];
        m_wid = exp_g;
        m_ov  = 1'b1;
        m_ptr = (exp_g + 1) % NW;
        hv[exp_g] = 1'b0;
      end else if (m_ov && ir) begin
        m_ov = 1'b0;
      end
    end
  endtask

  task automatic settle();
    drive();
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clock);
    model_commit();
    @(negedge clock);
  endtask

  task automatic new_head(input int w, input int rd, input int rs1, input int rs2, input int rs3);
    head[w].pc  = $urandom;
    head[w].op  = OB'($urandom);
    head[w].rd  = RB'(rd);
    head[w].rs1 = RB'(rs1);
    head[w].rs2 = RB'(rs2);
    head[w].rs3 = RB'(rs3);
    head[w].tm  = NL'($urandom);
    head[w].raw = {$urandom, $urandom};
    hv[w] = 1'b1;
  endtask

  task automatic reset_dut();
    rstn = 1'b0; wbv = 1'b0; ir = 1'b1;
    for (int w = 0; w < NW; w++) hv[w] = 1'b0;
    settle(); advance();
    settle(); advance();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; wbv = 1'b0; ir = 1'b1;
    for (int w = 0; w < NW; w++) new_head(w, 0, 0, 0, 0);
    settle();
    total_cnt++;
    if (ibuf_ready !== 8'h00) $display("FAIL reset_ready_in_reset got=%h want=00", ibuf_ready);
    else pass_cnt++;
    advance();
    for (int w = 0; w < NW; w++) hv[w] = 1'b0;
    settle(); advance();
    rstn = 1'b1;
    settle();
    total_cnt++;
    if ({issue_wid, issue_pc, issue_raw} !== '0) $display("FAIL reset_data got=%h want=0", {issue_wid, issue_pc, issue_raw});
    else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      settle();
      total_cnt++;
      if (idle !== 1'b1 || issue_valid !== 1'b0 || ibuf_ready !== 8'h00)
        $display("FAIL reset_idle c=%0d got idle=%b valid=%b ready=%h want 1/0/00", c, idle, issue_valid, ibuf_ready);
      else pass_cnt++;
      advance();
    end
  endtask

  task automatic test_round_robin();
    int order[3];
    order = '{0, 3, 5};
    reset_dut();
    new_head(0, 0, 0, 0, 0); new_head(3, 0, 0, 0, 0); new_head(5, 0, 0, 0, 0);
    ir = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      total_cnt++;
      if (ibuf_ready !== (8'h01 << order[k]) || !$onehot(ibuf_ready))
        $display("FAIL rr_order k=%0d got=%h want=%h", k, ibuf_ready, 8'h01 << order[k]);
      else pass_cnt++;
      if (k > 0) begin
        total_cnt++;
        if (issue_valid !== 1'b1 || int'(issue_wid) != order[k-1])
          $display("FAIL rr_issue k=%0d got v=%b wid=%0d want 1/%0d", k, issue_valid, issue_wid, order[k-1]);
        else pass_cnt++;
      end
      advance();
    end
    settle();
    total_cnt++;
    if (issue_valid !== 1'b1 || issue_wid !== 3'd5 || issue_pc !== m_out.pc)
      $display("FAIL rr_last got v=%b wid=%0d pc=%h want 1/5/%h", issue_valid, issue_wid, issue_pc, m_out.pc);
    else pass_cnt++;
    total_cnt++;
    if (dut.rr_ptr_q !== 3'd6) $display("FAIL rr_ptr got=%0d want=6", dut.rr_ptr_q);
    else pass_cnt++;
    advance();
    new_head(0, 0, 0, 0, 0); new_head(7, 0, 0, 0, 0);
    settle();
    total_cnt++;
    if (ibuf_ready !== 8'h80) $display("FAIL rr_wrap got=%h want=80", ibuf_ready);
    else pass_cnt++;
    advance();
    settle(); advance();
  endtask

  task automatic test_wb_bypass();
    logic [AL-1:0] pc2;
    reset_dut();
    ir = 1'b1;
    new_head(2, 7, 0, 0, 0);
    settle();
    total_cnt++;
    if (ibuf_ready !== 8'h04) $display("FAIL byp_first got=%h want=04", ibuf_ready);
    else pass_cnt++;
    advance();
    new_head(2, 0, 7, 0, 0);
    pc2 = head[2].pc;
    for (int c = 0; c < 3; c++) begin
      settle();
      total_cnt++;
      if (ibuf_ready !== 8'h00) $display("FAIL byp_stall c=%0d got=%h want=00", c, ibuf_ready);
      else pass_cnt++;
      advance();
    end
    wbv = 1'b1; wbw = 2; wbr = 7;
    settle();
    total_cnt++;
    if (ibuf_ready !== 8'h04) $display("FAIL byp_same_cycle got=%h want=04", ibuf_ready);
    else pass_cnt++;
    advance();
    wbv = 1'b0;
    settle();
    total_cnt++;
    if (issue_valid !== 1'b1 || issue_wid !== 3'd2 || issue_rs1 !== 8'd7 || issue_pc !== pc2)
      $display("FAIL byp_issue got v=%b wid=%0d rs1=%0d pc=%h want 1/2/7/%h", issue_valid, issue_wid, issue_rs1, issue_pc, pc2);
    else pass_cnt++;
    advance();
  endtask

  task automatic test_backpressure();
    logic [AL-1:0] pc1;
    reset_dut();
    ir = 1'b0;
    new_head(1, 0, 0, 0, 0); new_head(4, 0, 0, 0, 0); new_head(6, 0, 0, 0, 0);
    pc1 = head[1].pc;
    settle();
    total_cnt++;
    if (ibuf_ready !== 8'h02) $display("FAIL bp_first got=%h want=02", ibuf_ready);
    else pass_cnt++;
    advance();
    for (int c = 0; c < 5; c++) begin
      settle();
      total_cnt++;
      if (ibuf_ready !== 8'h00 || issue_valid !== 1'b1 || issue_wid !== 3'd1 || issue_pc !== pc1)
        $display("FAIL bp_hold c=%0d got ready=%h v=%b wid=%0d pc=%h want 00/1/1/%h", c, ibuf_ready, issue_valid, issue_wid, issue_pc, pc1);
      else pass_cnt++;
      advance();
    end
    ir = 1'b1;
    settle();
    total_cnt++;
    if (ibuf_ready !== 8'h10) $display("FAIL bp_release got=%h want=10", ibuf_ready);
    else pass_cnt++;
    advance();
    settle();
    total_cnt++;
    if (ibuf_ready !== 8'h40 || issue_wid !== 3'd4 || issue_valid !== 1'b1)
      $display("FAIL bp_b2b1 got ready=%h wid=%0d v=%b want 40/4/1", ibuf_ready, issue_wid, issue_valid);
    else pass_cnt++;
    advance();
    settle();
    total_cnt++;
    if (issue_wid !== 3'd6 || issue_valid !== 1'b1 || issue_pc !== m_out.pc)
      $display("FAIL bp_b2b2 got wid=%0d v=%b pc=%h want 6/1/%h", issue_wid, issue_valid, issue_pc, m_out.pc);
    else pass_cnt++;
    advance();
  endtask

  task automatic test_clear_set();
    reset_dut();
    ir = 1'b1;
    new_head(1, 4, 0, 0, 0);
    settle(); advance();
    new_head(1, 4, 0, 0, 0);
    settle();
    total_cnt++;
    if (ibuf_ready !== 8'h00) $display("FAIL cs_waw_stall got=%h want=00", ibuf_ready);
    else pass_cnt++;
    advance();
    wbv = 1'b1; wbw = 1; wbr = 4;
    settle();
    total_cnt++;
    if (ibuf_ready !== 8'h02) $display("FAIL cs_grant got=%h want=02", ibuf_ready);
    else pass_cnt++;
    advance();
    wbv = 1'b0;
    new_head(1, 0, 4, 0, 0);
    settle();
    total_cnt++;
    if (ibuf_ready !== 8'h00 || dut.busy_q[1][4] !== 1'b1)
      $display("FAIL cs_set_wins got ready=%h busy14=%b want 00/1", ibuf_ready, dut.busy_q[1][4]);
    else pass_cnt++;
    advance();
    settle();
    total_cnt++;
    if (idle !== 1'b0 || issue_valid !== 1'b0) $display("FAIL cs_idle got idle=%b v=%b want 0/0", idle, issue_valid);
    else pass_cnt++;
    advance();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    ir = 1'b1;
    new_head(0, 3, 0, 0, 0); new_head(1, 5, 0, 0, 0); new_head(2, 9, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin settle(); advance(); end
    ir = 1'b0;
    settle();
    total_cnt++;
    if (issue_valid !== 1'b1 || issue_wid !== 3'd2 || idle !== 1'b0)
      $display("FAIL rm_before got v=%b wid=%0d idle=%b want 1/2/0", issue_valid, issue_wid, idle);
    else pass_cnt++;
    advance();
    rstn = 1'b0;
    settle(); advance();
    settle();
    total_cnt++;
    if (issue_valid !== 1'b0 || idle !== 1'b1 || dut.busy_q !== '0 || issue_pc !== '0)
      $display("FAIL rm_after got v=%b idle=%b pc=%h want 0/1/0", issue_valid, idle, issue_pc);
    else pass_cnt++;
    rstn = 1'b1;
    advance();
  endtask

  task automatic test_random();
    reset_dut();
    for (int n = 0; n < 600; n++) begin
      for (int w = 0; w < NW; w++)
        if (!hv[w] && $urandom_range(0, 2) == 0)
          new_head(w, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 0);
      wbv  = ($urandom_range(0, 1) == 1);
      wbw  = $urandom_range(0, NW - 1);
      wbr  = $urandom_range(0, 7);
      ir   = ($urandom_range(0, 3) != 0);
      rstn = ($urandom_range(0, 149) != 0);
      settle();
      total_cnt++;
      if (ibuf_ready !== exp_ready) $display("FAIL rnd_ready n=%0d got=%h want=%h", n, ibuf_ready, exp_ready);
      else pass_cnt++;
      total_cnt++;
      if (issue_valid !== m_ov) $display("FAIL rnd_valid n=%0d got=%b want=%b", n, issue_valid, m_ov);
      else pass_cnt++;
      if (m_ov) begin
        total_cnt++;
        if ({issue_wid, issue_pc, issue_op, issue_rd, issue_rs1, issue_rs2, issue_rs3, issue_tmask, issue_raw} !==
            {3'(m_wid), m_out.pc, m_out.op, m_out.rd, m_out.rs1, m_out.rs2, m_out.rs3, m_out.tm, m_out.raw})
          $display("FAIL rnd_data n=%0d got wid=%0d pc=%h want wid=%0d pc=%h", n, issue_wid, issue_pc, m_wid, m_out.pc);
        else pass_cnt++;
      end
      total_cnt++;
      if (idle !== m_idle()) $display("FAIL rnd_idle n=%0d got=%b want=%b", n, idle, m_idle());
      else pass_cnt++;
      advance();
    end
  endtask

  initial begin
    rstn = 1'b0; wbv = 1'b0; wbw = 0; wbr = 0; ir = 1'b1;
    for (int w = 0; w < NW; w++) begin hv[w] = 1'b0; head[w] = '0; m_busy[w] = '0; end
    m_ptr = 0; m_ov = 1'b0; m_wid = 0; m_out = '0; exp_g = -1; exp_ready = '0;
    drive();
    @(negedge clock);
    test_reset();
    test_round_robin();
    test_wb_bypass();
    test_backpressure();
    test_clear_set();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/warp_issue_scheduler.md
# warp_issue_scheduler

Downstream consumer of the per-warp instruction-buffer heads produced by the Cyclotron frontend. Each cycle it checks every warp's head instruction against a per-warp register scoreboard and picks one hazard-free warp round-robin. It pops that head via `ibuf_ready` and presents the instruction on a registered valid/ready issue port to the execute stage. Writeback reports clear scoreboard entries.

## Interface
Parameters:
- `ARCH_LEN`, 32, PC width
- `INST_BITS`, 64, raw instruction width
- `NUM_WARPS`, 8, warp count
- `NUM_LANES`, 16, thread-mask width
- `OP_BITS`, 9, opcode width (ext:noext)
- `REG_BITS`, 8, register address width; `NUM_REGS = 2**REG_BITS`
- `WARP_ID_BITS`, `$clog2(NUM_WARPS)`, derived

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-low reset.
- `ibuf_valid` in NUM_WARPS: head valid per warp.
- `ibuf_ready` out NUM_WARPS: pop strobe; one-hot or zero.
- `ibuf_pc` in NUM_WARPS*ARCH_LEN: head fields, warp g at slice `[W*g +: W]`.
- `ibuf_op` in NUM_WARPS*OP_BITS: head fields, same slicing.
- `ibuf_rd`, `ibuf_rs1`, `ibuf_rs2`, `ibuf_rs3` in NUM_WARPS*REG_BITS each: head fields, same slicing.
- `ibuf_tmask` in NUM_WARPS*NUM_LANES: head fields, same slicing.
- `ibuf_raw` in NUM_WARPS*INST_BITS: head fields, same slicing.
- `wb_valid` in 1: writeback clears `wb_rd` of `wb_wid`.
- `wb_wid` in WARP_ID_BITS: writeback warp.
- `wb_rd` in REG_BITS: writeback register.
- `issue_valid` out 1: registered output valid.
- `issue_ready` in 1: execute accepts.
- `issue_wid` out WARP_ID_BITS: issued instruction fields.
- `issue_pc`, `issue_op`, `issue_rd`, `issue_rs1`, `issue_rs2`, `issue_rs3`, `issue_tmask`, `issue_raw` out: issued instruction fields, widths as the inputs.
- `idle` out 1: output empty and no scoreboard bit set.

## Operation
- Scoreboard: `busy[w][r]`, NUM_WARPS x NUM_REGS bits. Register 0 is never busy; `rd==0` means no destination.
- Eligibility of warp w:
  - `ibuf_valid[w]`, and
  - none of rs1/rs2/rs3/rd (non-zero) is busy in `busy_eff[w]`, where `busy_eff = busy & ~wb_clear_this_cycle`. This is a same-cycle writeback bypass covering RAW and WAW.
- Output slot accepts when `!issue_valid || issue_ready`. If it does not accept, no warp is granted.
- Arbitration: round-robin over eligible warps, starting at `rr_ptr`. On a grant to warp g, set `rr_ptr <= g+1` (mod NUM_WARPS). With no grant, `rr_ptr` holds.
- On a grant:
  - assert `ibuf_ready[g]`;
  - latch the head fields and `g` into the output register;
  - set `busy[g][rd]` if `rd != 0`.
- Busy update per bit: `next = (busy & ~clr) | set`. Set wins over a simultaneous clear on the same warp/register.
- A writeback to a non-busy bit is a no-op. `wb_rd==0` is ignored.
- Output register behaviour:
  - cleared on `issue_valid && issue_ready` with no new grant;
  - overwritten with a grant in the same cycle as acceptance, giving back-to-back throughput of 1/cycle.
- `idle = !issue_valid && (busy == 0)`.

## Timing
- Reset (`reset==0` at posedge):
  - `busy`, `rr_ptr`, and `issue_valid` are cleared to 0;
  - all `issue_*` data outputs are 0;
  - `ibuf_ready` is 0 while in reset;
  - `idle` is 1 after reset.
- Reset mid-operation drops the output instruction and all scoreboard state.
- `ibuf_ready` is combinational from `ibuf_*`, `busy`, `wb_*`, `issue_valid`, and `issue_ready`. A head valid and eligible at cycle N is popped at edge N.
- Latency: the instruction appears on `issue_*` with `issue_valid=1` in cycle N+1.
- `issue_*` is stable while `issue_valid && !issue_ready`.
- Writeback at cycle N makes a dependent head eligible in cycle N itself, via the bypass.
- Dependent back-to-back instructions in the same warp: the second stalls until the writeback of the first. Other warps proceed meanwhile.
- All-busy and all-empty conditions stall without changing `rr_ptr`.

## Structure
- Package `warp_issue_pkg`:
  - `issue_t` packed struct: wid, pc, op, rd, rs1, rs2, rs3, tmask, raw;
  - the derived width constants.
- Sub-module `rr_arbiter` (NUM_WARPS request vector plus pointer in, one-hot grant out, combinational; the pointer register lives in the parent).
- Scoreboard, eligibility, and the output register stay in `warp_issue_scheduler`.

## Test plan
- Reset release with all `ibuf_valid=0`: `idle=1`, `issue_valid=0`, and `ibuf_ready=0` for 10 cycles.
- Warps 0, 3, and 5 all eligible with `issue_ready=1`:
  - issue order is 0, 3, 5 on consecutive cycles;
  - `ibuf_ready` is one-hot each cycle;
  - `rr_ptr` ends at 6.
- Warp 2 issues `rd=7`, then its head has `rs1=7`:
  - the head is stalled;
  - `wb_valid=1`, `wb_wid=2`, `wb_rd=7` at cycle N gives `ibuf_ready[2]=1` at N and `issue_valid` at N+1.
- Backpressure: hold `issue_ready=0` for 5 cycles:
  - `issue_*` is unchanged;
  - no `ibuf_ready` is asserted;
  - releasing gives one issue per cycle.
- Same-cycle clear and set on warp 1, r4: writeback clears r4 while a new `rd=4` instruction issues. Afterwards `busy[1][4]=1` and `idle=0`.
- Reset asserted with `issue_valid=1` and 3 busy bits: on the next cycle `issue_valid=0`, `busy=0`, and `idle=1`.
